i2c_cfg_target: RTL and testbench

- Synthesizable I2C write-only target that sits on the codec-configuration bus and receives the 3-byte frames the initializer sends: device address+R/W, {reg[6:0],data[8]}, data[7:0].
- Decodes each frame, drives the ACK, and commits the 9-bit register value into a 16-entry shadow register file.
- Used as an on-chip codec model for loopback verification of the initializer and as a write-log/monitor in the audio bring-up path.

---
 rtl/i2c_pkg.sv | 8 +
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_cfg_target.sv | 116 +++++++++++
 tb/tb_i2c_cfg_target.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states and protocol constants for the codec configuration target
package i2c_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_ACK, S_IGNORE} state_t;
  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;
  localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
  localparam int FRAME_BYTES = 3;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and derives edge, START and STOP strobes
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_sdat,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_h, sda_h;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      scl_q <= '0;
      sda_q <= '0;
      scl_h <= 1'b0;
      sda_h <= 1'b0;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], i_sclk};
      sda_q <= {sda_q[SYNC_STAGES-2:0], i_sdat};
      scl_h <= o_scl;
      sda_h <= o_sda;
    end
  assign o_scl       = scl_q[SYNC_STAGES-1];
  assign o_sda       = sda_q[SYNC_STAGES-1];
  assign o_scl_rise  = o_scl & ~scl_h;
  assign o_scl_fall  = ~o_scl & scl_h;
  assign o_start_det = o_scl & scl_h & sda_h & ~o_sda;
  assign o_stop_det  = o_scl & scl_h & ~sda_h & o_sda;
endmodule

// File: rtl/i2c_cfg_target.sv
// i2c_cfg_target: write-only I2C target that logs 3-byte codec frames into a shadow register file
module i2c_cfg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = CODEC_DEV_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_REGS    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_ack_oe,
  output logic       o_reg_valid,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy,
  output logic       o_err,
  output logic [7:0] o_frame_cnt
);
  logic unused_scl, sda, scl_rise, scl_fall, start_det, stop_det;
  state_t state, state_n;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] shreg, byte1, byte2;
  logic byte_done, ovr;
  logic accept, reject, commit, err_d;
  logic [8:0] shadow [NUM_REGS];
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sclk     (i_sclk),
    .i_sdat     (i_sdat),
    .o_scl      (unused_scl),
    .o_sda      (sda),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start_det(start_det),
    .o_stop_det (stop_det)
  );
  always_ff @(posedge i_clk)
    if (i_rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    if (start_det) begin
      state_n = S_RECV;
      err_d   = byte_cnt != 2'd0;
    end else if (stop_det) begin
      state_n = S_IDLE;
      commit  = byte_cnt == 2'(FRAME_BYTES) && !ovr;
      err_d   = !commit && byte_cnt != 2'd0;
    end else if (state == S_RECV && byte_done && scl_fall) begin
      accept  = byte_cnt == 2'd0 ? shreg == {DEV_ADDR, I2C_WR} : byte_cnt != 2'd3;
      reject  = !accept;
      err_d   = byte_cnt == 2'd3;
      state_n = accept ? S_ACK : S_IGNORE;
    end else if (state == S_ACK && scl_fall) begin
      state_n = S_RECV;
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      bit_cnt     <= 3'd7;
      byte_cnt    <= 2'd0;
      shreg       <= '0;
      byte1       <= '0;
      byte2       <= '0;
      byte_done   <= 1'b0;
      ovr         <= 1'b0;
      o_reg_valid <= 1'b0;
      o_err       <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_data  <= '0;
      o_frame_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else begin
      o_reg_valid <= commit;
      o_err       <= err_d;
      if (start_det || stop_det) begin
        bit_cnt   <= 3'd7;
        byte_cnt  <= 2'd0;
        byte_done <= 1'b0;
        ovr       <= 1'b0;
      end else if (state == S_RECV && scl_rise && !byte_done) begin
        shreg     <= {shreg[6:0], sda};
        byte_done <= bit_cnt == 3'd0;
        bit_cnt   <= bit_cnt - 3'd1;
      end else if (accept) begin
        byte_done <= 1'b0;
        if (byte_cnt == 2'd1) byte1 <= shreg;
        if (byte_cnt == 2'd2) byte2 <= shreg;
      end else if (reject) begin
        byte_done <= 1'b0;
        ovr       <= byte_cnt == 2'd3;
      end else if (state == S_ACK && scl_fall) begin
        byte_cnt <= byte_cnt + 2'd1;
        bit_cnt  <= 3'd7;
      end
      if (commit) begin
        o_reg_addr  <= byte1[7:1];
        o_reg_data  <= {byte1[0], byte2};
        o_frame_cnt <= o_frame_cnt + 8'd1;
        if (byte1[7:5] == 3'd0) shadow[byte1[4:1]] <= {byte1[0], byte2};
      end
    end
  assign o_ack_oe  = state == S_ACK;
  assign o_busy    = state != S_IDLE;
  assign o_rd_data = shadow[i_rd_addr];
endmodule

// File: tb/tb_i2c_cfg_target.sv
// tb_i2c_cfg_target: directed frame vectors and corner sequences against a small bus-level model
module tb_i2c_cfg_target;
  localparam int Q = 5;
  logic clk = 1'b0, rst = 1'b1, scl_drv = 1'b1, sda_drv = 1'b1, sdat;
  logic [3:0] rd_addr = '0;
  logic o_ack_oe, o_reg_valid, o_busy, o_err;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data, o_rd_data;
  logic [7:0] o_frame_cnt;
  int checks = 0, errors = 0;
  int valid_n = 0, err_n = 0, ack_n = 0;
  logic ack_q = 1'b0;
  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [2:0] ack;
    logic       valid;
    logic [6:0] addr;
    logic [8:0] data;
    logic       err;
  } vec_t;
  vec_t vecs [4];
  logic [8:0] cfg [10];
  logic [8:0] exp_sh [16];
  logic [6:0] last_addr;
  logic [8:0] last_data;
  logic [7:0] exp_fc;
  assign sdat = sda_drv & ~o_ack_oe;
  always #5 clk = ~clk;
  i2c_cfg_target dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(scl_drv), .i_sdat(sdat),
    .o_ack_oe(o_ack_oe), .o_reg_valid(o_reg_valid), .o_reg_addr(o_reg_addr),
    .o_reg_data(o_reg_data), .i_rd_addr(rd_addr), .o_rd_data(o_rd_data),
    .o_busy(o_busy), .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );
  always @(negedge clk) begin
    if (o_reg_valid) valid_n++;
    if (o_err) err_n++;
    if (o_ack_oe && !ack_q) ack_n++;
    ack_q = o_ack_oe;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask
  task automatic i2c_start();
    sda_drv = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_drv = 1'b0; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask
  task automatic i2c_stop();
    sda_drv = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_drv = 1'b1; wait_q();
    wait_q();
  endtask
  task automatic send_bit(input logic b);
    sda_drv = b; wait_q();
    scl_drv = 1'b1; wait_q(); wait_q();
    scl_drv = 1'b0; wait_q();
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    ack = o_ack_oe; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask
  task automatic frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, output logic [2:0] acks);
    logic a0, a1, a2;
    i2c_start();
    send_byte(b0, a0);
    send_byte(b1, a1);
    send_byte(b2, a2);
    i2c_stop();
    acks = {a0, a1, a2};
  endtask
  task automatic model_commit(input logic [6:0] addr, input logic [8:0] data);
    last_addr = addr;
    last_data = data;
    exp_fc++;
    if (addr[6:4] == 3'd0) exp_sh[addr[3:0]] = data;
  endtask
  initial begin
    int v0, e0, a0;
    logic [2:0] acks;
    logic a;
    vecs[0] = '{8'h34, 8'h08, 8'h15, 3'b111, 1'b1, 7'h04, 9'h015, 1'b0};
    vecs[1] = '{8'h34, 8'h29, 8'hAB, 3'b111, 1'b1, 7'h14, 9'h1AB, 1'b0};
    vecs[2] = '{8'h36, 8'h08, 8'h15, 3'b000, 1'b0, 7'h00, 9'h000, 1'b0};
    vecs[3] = '{8'h35, 8'h08, 8'h15, 3'b000, 1'b0, 7'h00, 9'h000, 1'b0};
    cfg = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h015, 9'h000, 9'h000, 9'h042, 9'h019, 9'h001};
    for (int i = 0; i < 16; i++) exp_sh[i] = '0;
    last_addr = '0;
    last_data = '0;
    exp_fc = '0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", 0, o_ack_oe, 0);
    check("rst_valid", 0, o_reg_valid, 0);
    check("rst_addr", 0, o_reg_addr, 0);
    check("rst_data", 0, o_reg_data, 0);
    check("rst_busy", 0, o_busy, 0);
    check("rst_err", 0, o_err, 0);
    check("rst_fcnt", 0, o_frame_cnt, 0);
    check("rst_rd", 0, o_rd_data, 0);
    wait_q();
    for (int k = 0; k < 4; k++) begin
      v0 = valid_n; e0 = err_n; a0 = ack_n;
      frame3(vecs[k].b0, vecs[k].b1, vecs[k].b2, acks);
      if (vecs[k].valid) model_commit(vecs[k].addr, vecs[k].data);
      check("vec_acks", k, acks, vecs[k].ack);
      check("vec_ack_pulses", k, ack_n - a0, $countones(vecs[k].ack));
      check("vec_valid", k, valid_n - v0, vecs[k].valid);
      check("vec_err", k, err_n - e0, vecs[k].err);
      check("vec_busy", k, o_busy, 0);
      check("vec_addr", k, o_reg_addr, last_addr);
      check("vec_data", k, o_reg_data, last_data);
      check("vec_fcnt", k, o_frame_cnt, exp_fc);
      rd_addr = 4'd4; #1;
      check("vec_rd4", k, o_rd_data, exp_sh[4]);
    end
    v0 = valid_n; e0 = err_n;
    i2c_start();
    check("rs_busy", 0, o_busy, 1);
    send_byte(8'h34, a);
    send_byte(8'h0E, a);
    check("rs_ack1", 0, a, 1);
    frame3(8'h34, 8'h0E, 8'h42, acks);
    model_commit(7'h07, 9'h042);
    check("rs_acks", 0, acks, 3'b111);
    check("rs_err", 0, err_n - e0, 1);
    check("rs_valid", 0, valid_n - v0, 1);
    check("rs_addr", 0, o_reg_addr, 7'h07);
    check("rs_data", 0, o_reg_data, 9'h042);
    rd_addr = 4'd7; #1;
    check("rs_rd7", 0, o_rd_data, 9'h042);
    v0 = valid_n; e0 = err_n;
    i2c_start();
    send_byte(8'h34, a); check("ovr_ack", 0, a, 1);
    send_byte(8'h0A, a); check("ovr_ack", 1, a, 1);
    send_byte(8'h11, a); check("ovr_ack", 2, a, 1);
    send_byte(8'h22, a); check("ovr_ack", 3, a, 0);
    i2c_stop();
    check("ovr_valid", 0, valid_n - v0, 0);
    check("ovr_err", 0, (err_n - e0) > 0, 1);
    check("ovr_fcnt", 0, o_frame_cnt, exp_fc);
    check("ovr_addr", 0, o_reg_addr, 7'h07);
    v0 = valid_n; e0 = err_n;
    i2c_start();
    send_byte(8'h34, a);
    check("mid_ack0", 0, a, 1);
    for (int i = 7; i >= 4; i--) send_bit(i[0]);
    rst = 1'b1;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_q(); wait_q();
    for (int i = 0; i < 16; i++) exp_sh[i] = '0;
    last_addr = '0; last_data = '0; exp_fc = '0;
    check("mid_valid", 0, valid_n - v0, 0);
    check("mid_err", 0, err_n - e0, 0);
    check("mid_busy", 0, o_busy, 0);
    check("mid_fcnt", 0, o_frame_cnt, 0);
    rd_addr = 4'd7; #1;
    check("mid_rd7", 0, o_rd_data, 0);
    for (int i = 0; i < 10; i++) begin
      logic [6:0] r;
      r = 7'(i);
      frame3(8'h34, {r, cfg[i][8]}, cfg[i][7:0], acks);
      model_commit(r, cfg[i]);
      check("cfg_acks", i, acks, 3'b111);
    end
    check("cfg_fcnt", 0, o_frame_cnt, 8'd10);
    check("cfg_addr", 0, o_reg_addr, 7'h09);
    check("cfg_data", 0, o_reg_data, 9'h001);
    for (int i = 0; i < 10; i++) begin
      rd_addr = 4'(i); #1;
      check("cfg_shadow", i, o_rd_data, cfg[i]);
    end
    rd_addr = 4'd12; #1;
    check("cfg_shadow", 12, o_rd_data, exp_sh[12]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
